// File: rtl/master_out_if.sv
// rtl/master_out_if.sv - serial bus lanes between master_out and a bus slave input port
interface master_out_if;
    logic master_valid;
    logic slave_ready;
    logic tx_address;
    logic tx_burst;
    logic tx_data;
    logic write_enable;
    logic read_enable;

    modport master (
        output master_valid,
        output tx_address,
        output tx_burst,
        output tx_data,
        output write_enable,
        output read_enable,
        input  slave_ready
    );

    modport slave (
        input  master_valid,
        input  tx_address,
        input  tx_burst,
        input  tx_data,
        input  write_enable,
        input  read_enable,
        output slave_ready
    );
endinterface

// File: rtl/master_out.sv
// rtl/master_out.sv - serial bus initiator: address/burst header then LSB-first data bytes
module master_out #(
    parameter int ADDR_LEN  = 12,
    parameter int BURST_LEN = 12,
    parameter int DATA_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 write,
    input  logic [ADDR_LEN-1:0]  address,
    input  logic [BURST_LEN-1:0] burst_len,
    input  logic [DATA_LEN-1:0]  wr_data,
    input  logic                 wr_data_valid,
    output logic                 wr_data_ready,
    output logic                 busy,
    output logic                 done,
    master_out_if.master         bus
);
    // Header lanes share one counter; the shorter lane is zero-extended so it idles at 0.
    localparam int HDR_LEN = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
    localparam int MAX_LEN = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, HEADER, DATA_LOAD, DATA, DONE} state_t;

    state_t               state;
    logic [HDR_LEN-1:0]   addr_sh;
    logic [HDR_LEN-1:0]   burst_sh;
    logic [DATA_LEN-1:0]  data_sh;
    logic [BURST_LEN-1:0] burst_len_reg;
    logic [BURST_LEN-1:0] beat_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 write_reg;

    logic master_valid_r;
    logic tx_address_r;
    logic tx_burst_r;
    logic tx_data_r;
    logic write_enable_r;
    logic read_enable_r;

    logic                hs;
    logic                hdr_last;
    logic                data_last;
    logic [HDR_LEN-1:0]  addr_next;
    logic [HDR_LEN-1:0]  burst_next;
    logic [DATA_LEN-1:0] data_next;

    assign hs         = master_valid_r & bus.slave_ready;
    assign hdr_last   = (bit_cnt == CNT_W'(HDR_LEN - 1));
    assign data_last  = (bit_cnt == CNT_W'(DATA_LEN - 1));
    assign addr_next  = addr_sh >> 1;
    assign burst_next = burst_sh >> 1;
    assign data_next  = data_sh >> 1;

    assign bus.master_valid = master_valid_r;
    assign bus.tx_address   = tx_address_r;
    assign bus.tx_burst     = tx_burst_r;
    assign bus.tx_data      = tx_data_r;
    assign bus.write_enable = write_enable_r;
    assign bus.read_enable  = read_enable_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr_sh        <= '0;
            burst_sh       <= '0;
            data_sh        <= '0;
            burst_len_reg  <= '0;
            beat_cnt       <= '0;
            bit_cnt        <= '0;
            write_reg      <= 1'b0;
            master_valid_r <= 1'b0;
            tx_address_r   <= 1'b0;
            tx_burst_r     <= 1'b0;
            tx_data_r      <= 1'b0;
            write_enable_r <= 1'b0;
            read_enable_r  <= 1'b0;
            wr_data_ready  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_sh        <= HDR_LEN'(address);
                        burst_sh       <= HDR_LEN'(burst_len);
                        burst_len_reg  <= burst_len;
                        write_reg      <= write;
                        bit_cnt        <= '0;
                        beat_cnt       <= '0;
                        master_valid_r <= 1'b1;
                        tx_address_r   <= address[0];
                        tx_burst_r     <= burst_len[0];
                        write_enable_r <= write;
                        read_enable_r  <= ~write;
                        busy           <= 1'b1;
                        state          <= HEADER;
                    end
                end

                HEADER: begin
                    if (hs) begin
                        addr_sh  <= addr_next;
                        burst_sh <= burst_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (hdr_last) begin
                            master_valid_r <= 1'b0;
                            tx_address_r   <= 1'b0;
                            tx_burst_r     <= 1'b0;
                            if (write_reg) begin
                                wr_data_ready <= 1'b1;
                                state         <= DATA_LOAD;
                            end else begin
                                done           <= 1'b1;
                                write_enable_r <= 1'b0;
                                read_enable_r  <= 1'b0;
                                state          <= DONE;
                            end
                        end else begin
                            tx_address_r <= addr_next[0];
                            tx_burst_r   <= burst_next[0];
                        end
                    end
                end

                DATA_LOAD: begin
                    if (wr_data_valid) begin
                        data_sh        <= wr_data;
                        bit_cnt        <= '0;
                        wr_data_ready  <= 1'b0;
                        master_valid_r <= 1'b1;
                        tx_data_r      <= wr_data[0];
                        state          <= DATA;
                    end
                end

                DATA: begin
                    if (hs) begin
                        data_sh <= data_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (data_last) begin
                            master_valid_r <= 1'b0;
                            tx_data_r      <= 1'b0;
                            // beat_cnt counts bytes already finished, so it never has to reach burst_len + 1
                            if (beat_cnt == burst_len_reg) begin
                                done           <= 1'b1;
                                write_enable_r <= 1'b0;
                                read_enable_r  <= 1'b0;
                                state          <= DONE;
                            end else begin
                                beat_cnt      <= beat_cnt + 1'b1;
                                wr_data_ready <= 1'b1;
                                state         <= DATA_LOAD;
                            end
                        end else begin
                            tx_data_r <= data_next[0];
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_master_out.sv
// tb/tb_master_out.sv - scoreboard bench for master_out with a bit-level transaction model
module tb_master_out;
    logic        clk;
    logic        reset;
    logic        start;
    logic        write;
    logic [11:0] address;
    logic [11:0] burst_len;
    logic [7:0]  wr_data;
    logic        wr_data_valid;
    logic        wr_data_ready;
    logic        busy;
    logic        done;

    master_out_if bus_if ();

    master_out #(.ADDR_LEN(12), .BURST_LEN(12), .DATA_LEN(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .write        (write),
        .address      (address),
        .burst_len    (burst_len),
        .wr_data      (wr_data),
        .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready),
        .busy         (busy),
        .done         (done),
        .bus          (bus_if)
    );

    typedef struct packed {
        logic a;
        logic b;
        logic d;
        logic we;
        logic re;
    } bit_t;

    typedef struct {
        int start_cyc;
        int base;
        int stall0;
        int hs0;
        int nbytes;
        int bits_end;
        bit timed;
    } done_t;

    bit_t       exp_bits[$];
    done_t      exp_done[$];
    logic [7:0] wr_bytes[$];
    logic [7:0] fixed_bytes[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int stall_total = 0;
    int wr_hs_total = 0;
    int bits_popped = 0;
    int bits_pushed = 0;
    int sr_mode = 0;
    int dv_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc + 1 < c) tick;
    endtask

    // Reference model: a transaction is a header of 12 bit pairs then 8 LSB-first bits per byte.
    task automatic push_txn(input logic wr, input logic [11:0] addr, input logic [11:0] bl,
                            input bit timed, input int scyc);
        bit_t       e;
        done_t      d;
        logic [7:0] by;
        for (int i = 0; i < 12; i++) begin
            e = '{a: addr[i], b: bl[i], d: 1'b0, we: wr, re: !wr};
            exp_bits.push_back(e);
        end
        bits_pushed += 12;
        if (wr) begin
            for (int k = 0; k <= int'(bl); k++) begin
                by = (fixed_bytes.size() > 0) ? fixed_bytes.pop_front() : 8'($urandom);
                wr_bytes.push_back(by);
                for (int j = 0; j < 8; j++) begin
                    e = '{a: 1'b0, b: 1'b0, d: by[j], we: 1'b1, re: 1'b0};
                    exp_bits.push_back(e);
                end
                bits_pushed += 8;
            end
        end
        d.start_cyc = scyc;
        d.timed     = timed;
        d.stall0    = stall_total;
        d.hs0       = wr_hs_total;
        d.nbytes    = wr ? int'(bl) + 1 : 0;
        d.bits_end  = bits_pushed;
        d.base      = wr ? 12 + (int'(bl) + 1) * 9 + 1 : 13;
        exp_done.push_back(d);
    endtask

    task automatic flush_model;
        exp_bits.delete();
        exp_done.delete();
        wr_bytes.delete();
        bits_pushed = bits_popped;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (exp_done.size() > 0 && n < bound) begin
            tick;
            n++;
        end
        if (exp_done.size() > 0) begin
            chk("done_timeout", 32'(exp_done.size()), 32'd0);
            reset = 1'b1;
            tick;
            tick;
            flush_model();
            reset = 1'b0;
        end else begin
            chk("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [11:0] bl,
                           input bit timed, input int bound);
        push_txn(wr, addr, bl, timed, cyc + 1);
        start = 1'b1; write = wr; address = addr; burst_len = bl;
        tick;
        start = 1'b0;
        write = 1'($urandom); address = 12'($urandom); burst_len = 12'($urandom);
        wait_idle(bound);
    endtask

    // Monitor / scoreboard
    initial begin
        bit_t  cur;
        bit_t  prev;
        bit_t  e;
        done_t d;
        logic  pv_stall;
        pv_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pv_stall = 1'b0;
            end else begin
                cur = '{a: bus_if.tx_address, b: bus_if.tx_burst, d: bus_if.tx_data,
                        we: bus_if.write_enable, re: bus_if.read_enable};
                if (cur.we && cur.re) chk("we_re_exclusive", 32'({cur.we, cur.re}), 32'b01);
                if (!bus_if.master_valid) chk("tx_zero_when_invalid", 32'({cur.a, cur.b, cur.d}), 32'd0);
                if (pv_stall) chk("stall_hold", 32'({bus_if.master_valid, cur}), 32'({1'b1, prev}));
                if (wr_data_ready)
                    chk("wr_ready_context", 32'({bus_if.master_valid, cur.we, busy}), 32'b011);
                if (bus_if.master_valid && bus_if.slave_ready) begin
                    if (exp_bits.size() == 0) begin
                        chk("unexpected_bit", 32'(cur), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_bits.pop_front();
                        bits_popped++;
                        chk("serial_bit", 32'(cur), 32'(e));
                    end
                end
                if (bus_if.master_valid && !bus_if.slave_ready) stall_total++;
                if (wr_data_ready && wr_data_valid) wr_hs_total++;
                if (done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_outputs", 32'({bus_if.master_valid, cur.we, cur.re, busy}), 32'b0001);
                        chk("done_bytes", 32'(wr_hs_total - d.hs0), 32'(d.nbytes));
                        chk("done_bits", 32'(bits_popped), 32'(d.bits_end));
                        if (d.timed)
                            chk("done_latency", 32'(cyc - d.start_cyc),
                                32'(d.base + stall_total - d.stall0));
                    end
                end
                pv_stall = bus_if.master_valid && !bus_if.slave_ready;
                prev = cur;
            end
        end
    end

    // Slave-side and write-byte source driver
    initial begin
        int   ph;
        logic hs_pending;
        ph = 0;
        hs_pending = 1'b0;
        bus_if.slave_ready = 1'b0;
        wr_data_valid = 1'b0;
        wr_data = 8'd0;
        forever begin
            @(posedge clk);
            #2;
            if (hs_pending && wr_bytes.size() > 0) void'(wr_bytes.pop_front());
            ph++;
            case (sr_mode)
                0:       bus_if.slave_ready = 1'b1;
                1:       bus_if.slave_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: bus_if.slave_ready = 1'($urandom);
            endcase
            if (wr_bytes.size() > 0 && (dv_mode == 0 || $urandom_range(0, 1) == 1)) begin
                wr_data_valid = 1'b1;
                wr_data = wr_bytes[0];
            end else begin
                wr_data_valid = 1'b0;
                wr_data = 8'($urandom);
            end
            hs_pending = wr_data_ready && wr_data_valid;
        end
    end

    initial begin
        int          t0;
        logic        rw;
        logic [11:0] ra;
        logic [11:0] rb;
        reset = 1'b1; start = 1'b0; write = 1'b0; address = '0; burst_len = '0;
        repeat (3) tick;
        chk("reset_outputs", 32'({wr_data_ready, busy, done, bus_if.master_valid, bus_if.tx_address,
                                  bus_if.tx_burst, bus_if.tx_data, bus_if.write_enable,
                                  bus_if.read_enable}), 32'd0);
        reset = 1'b0;
        tick;

        fixed_bytes.push_back(8'h3C);
        run_txn(1'b1, 12'hA5C, 12'd0, 1'b1, 200);

        fixed_bytes.push_back(8'h01); fixed_bytes.push_back(8'h80); fixed_bytes.push_back(8'hFF);
        run_txn(1'b1, 12'h0F3, 12'd2, 1'b1, 300);

        sr_mode = 1;
        fixed_bytes.push_back(8'h3C);
        run_txn(1'b1, 12'hA5C, 12'd0, 1'b1, 300);
        sr_mode = 0;

        run_txn(1'b0, 12'h123, 12'd7, 1'b1, 200);

        // Reset in the 4th DATA cycle of a 2-byte write
        t0 = cyc + 1;
        push_txn(1'b1, 12'h5A3, 12'd1, 1'b0, t0);
        start = 1'b1; write = 1'b1; address = 12'h5A3; burst_len = 12'd1;
        tick;
        start = 1'b0;
        tick_to(t0 + 17);
        reset = 1'b1;
        tick;
        flush_model();
        chk("reset_abort_outputs", 32'({wr_data_ready, busy, done, bus_if.master_valid, bus_if.tx_address,
                                        bus_if.tx_burst, bus_if.tx_data, bus_if.write_enable,
                                        bus_if.read_enable}), 32'd0);
        reset = 1'b0;
        repeat (30) tick;
        run_txn(1'b1, 12'h2B7, 12'd1, 1'b1, 300);

        // Start while busy is ignored; start held through DONE is taken in the next IDLE cycle
        t0 = cyc + 1;
        push_txn(1'b1, 12'h3C5, 12'd0, 1'b1, t0);
        start = 1'b1; write = 1'b1; address = 12'h3C5; burst_len = 12'd0;
        tick;
        start = 1'b0;
        tick_to(t0 + 5);
        start = 1'b1; write = 1'b0; address = 12'h0F0; burst_len = 12'd9;
        tick;
        start = 1'b0;
        tick_to(t0 + 15);
        push_txn(1'b0, 12'h7E1, 12'd3, 1'b1, t0 + 23);
        start = 1'b1; write = 1'b0; address = 12'h7E1; burst_len = 12'd3;
        tick_to(t0 + 23);
        chk("held_start_idle_busy", 32'(busy), 32'd0);
        tick;
        chk("held_start_accept", 32'(bus_if.master_valid), 32'd1);
        start = 1'b0;
        wait_idle(200);

        for (int n = 0; n < 12; n++) begin
            sr_mode = $urandom_range(0, 2);
            dv_mode = $urandom_range(0, 1);
            rw = 1'($urandom);
            ra = 12'($urandom);
            rb = 12'($urandom_range(0, 3));
            run_txn(rw, ra, rb, dv_mode == 0, 2000);
        end
        sr_mode = 0;
        dv_mode = 0;

        run_txn(1'b1, 12'hFFF, 12'd4095, 1'b1, 40000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
